// File: rtl/echo_pkg.sv
// echo_pkg: shared definitions for the echo unit.
//   SAMPLE_W_DEF / ADDR_W_DEF : default sample width and delay-buffer address width
//   state_e                   : frame-processing FSM states
//   SAT_MAX_DEF / SAT_MIN_DEF : clamp limits at the default sample width
package echo_pkg;

   localparam int unsigned SAMPLE_W_DEF = 18;
   localparam int unsigned ADDR_W_DEF   = 12;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StWrite
   } state_e;

   // Limits for the default width; echo_unit derives the same limits from its own SAMPLE_W.
   localparam int SAT_MAX_DEF = 131071;
   localparam int SAT_MIN_DEF = -131072;

endpackage

// File: rtl/echo_ram.sv
// echo_ram: single-port synchronous delay-line RAM, 2**ADDR_W x SAMPLE_W.
//   clk   : clock
//   en    : access enable
//   we    : 1 = write wdata to addr, 0 = read addr into rdata (1-cycle latency)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data; holds its value across writes and idle cycles
// Contents are never cleared.
module echo_ram
   import echo_pkg::*;
#(
   parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [SAMPLE_W-1:0] wdata,
   output logic [SAMPLE_W-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [SAMPLE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/echo_unit.sv
// echo_unit: feedback echo effect for a stream of signed audio samples.
//   clk          : clock, rising edge
//   reset        : synchronous, active-high
//   new_frame    : one-cycle strobe, sample_in valid (ignored while a frame is in flight)
//   sample_in    : signed dry sample
//   echo_en      : 0 selects pass-through
//   delay        : echo delay in frames, sampled at new_frame
//   decay_shift  : arithmetic right shift on the echo term, sampled at new_frame
//   sample_out   : registered signed wet sample
//   sample_valid : one-cycle strobe when sample_out updates (3 cycles after new_frame)
// Build option: define ECHO_SATURATE_EN to clamp out-of-range sums instead of wrapping.
module echo_unit
   import echo_pkg::*;
#(
   parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       new_frame,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic                       echo_en,
   input  logic        [ADDR_W-1:0]   delay,
   input  logic        [2:0]          decay_shift,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       sample_valid
);

   localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

   state_e                     state_q, state_d;
   logic        [ADDR_W-1:0]   wp_q;
   logic        [ADDR_W:0]     fill_q;
   logic signed [SAMPLE_W-1:0] in_q;
   logic        [2:0]          shift_q;
   logic                       active_q;
   logic signed [SAMPLE_W-1:0] out_q;
   logic                       valid_q;

   logic                       ram_en, ram_we;
   logic        [ADDR_W-1:0]   ram_addr;
   logic        [SAMPLE_W-1:0] ram_rdata;
   logic signed [SAMPLE_W-1:0] echo, echo_scaled;
   logic        [SAMPLE_W-1:0] wet;

   // Read of the delayed sample is issued in the accept cycle; rdata then holds
   // through READ and WRITE because nothing else reads the RAM meanwhile.
   always_comb begin
      state_d  = state_q;
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = wp_q - delay;
      case (state_q)
         StIdle: begin
            if (new_frame) begin
               state_d = StRead;
               ram_en  = 1'b1;
            end
         end
         StRead: state_d = StWrite;
         StWrite: begin
            state_d  = StIdle;
            // A reset landing in WRITE aborts the frame, including its buffer write.
            ram_en   = !reset;
            ram_we   = !reset;
            ram_addr = wp_q;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      echo        = active_q ? $signed(ram_rdata) : '0;
      echo_scaled = echo >>> shift_q;
   end

`ifdef ECHO_SATURATE_EN
   localparam logic [SAMPLE_W:0] SAT_MAX = {2'b00, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W:0] SAT_MIN = {2'b11, {(SAMPLE_W-1){1'b0}}};

   logic signed [SAMPLE_W:0] sum;

   always_comb begin
      sum = $signed({in_q[SAMPLE_W-1], in_q}) + $signed({echo_scaled[SAMPLE_W-1], echo_scaled});
      // Top two bits differ only when the sum left the SAMPLE_W range.
      if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
         wet = sum[SAMPLE_W] ? SAT_MIN[SAMPLE_W-1:0] : SAT_MAX[SAMPLE_W-1:0];
      end else begin
         wet = sum[SAMPLE_W-1:0];
      end
   end
`else
   // Keeping only the low SAMPLE_W bits of the wide sum equals a SAMPLE_W-bit add.
   always_comb begin
      wet = in_q + echo_scaled;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         wp_q    <= '0;
         fill_q  <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= (state_q == StWrite);
         if (state_q == StIdle && new_frame) begin
            in_q     <= sample_in;
            shift_q  <= decay_shift;
            // fill only moves in WRITE, so the echo decision can be made up front.
            active_q <= echo_en && (delay != '0) && (fill_q >= {1'b0, delay});
         end
         if (state_q == StWrite) begin
            out_q <= wet;
            wp_q  <= wp_q + 1'b1;
            if (fill_q != FILL_MAX) begin
               fill_q <= fill_q + 1'b1;
            end
         end
      end
   end

   echo_ram #(
      .SAMPLE_W (SAMPLE_W),
      .ADDR_W   (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wet),
      .rdata (ram_rdata)
   );

   assign sample_out   = out_q;
   assign sample_valid = valid_q;

endmodule

// File: tb/tb_echo_unit.sv
module tb_echo_unit;

   localparam int SW    = 18;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 new_frame = 1'b0;
   logic signed [SW-1:0] sample_in = '0;
   logic                 echo_en = 1'b0;
   logic        [AW-1:0] delay = '0;
   logic        [2:0]    decay_shift = '0;
   logic signed [SW-1:0] sample_out;
   logic                 sample_valid;

   int checks = 0;
   int errors = 0;

   echo_unit #(
      .SAMPLE_W (SW),
      .ADDR_W   (AW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .new_frame    (new_frame),
      .sample_in    (sample_in),
      .echo_en      (echo_en),
      .delay        (delay),
      .decay_shift  (decay_shift),
      .sample_out   (sample_out),
      .sample_valid (sample_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reduce an unbounded sum to what a SAMPLE_W-bit output can hold.
   function automatic int limit(input int s);
      int lo, hi, t;
      lo = -(1 << (SW - 1));
      hi = (1 << (SW - 1)) - 1;
`ifdef ECHO_SATURATE_EN
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
`else
      t = s & ((1 << SW) - 1);
      if (t > hi) t -= (1 << SW);
      return t;
`endif
   endfunction

   // ---------------- behavioural model ----------------
   // hist holds every wet output produced since the last reset, oldest first.
   int  hist[$];
   int  cyc = 0;
   bit  pending = 0;
   int  pend_val, due;
   bit  exp_valid = 0;
   int  exp_out = 0;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         exp_valid = 0;
         if (reset) begin
            pending = 0;
            hist.delete();
         end else if (pending) begin
            if (cyc == due) begin
               hist.push_back(pend_val);
               exp_valid = 1;
               exp_out   = pend_val;
               pending   = 0;
            end
         end else if (new_frame) begin
            int n, fill, d, echo_v;
            n      = hist.size();
            fill   = (n < DEPTH) ? n : DEPTH;
            d      = int'(delay);
            echo_v = 0;
            if (echo_en && d != 0 && fill >= d) echo_v = hist[n - d];
            pend_val = limit(int'(sample_in) + (echo_v >>> int'(decay_shift)));
            pending  = 1;
            due      = cyc + 2;
         end
      end
   end

   // ---------------- compare process ----------------
   int obs[$];
   int obs_cyc[$];

   initial begin
      forever begin
         @(negedge clk);
         check("sample_valid", {31'b0, sample_valid}, {31'b0, exp_valid});
         if (exp_valid) check("sample_out", int'(sample_out), exp_out);
         if (sample_valid === 1'b1) begin
            obs.push_back(int'(sample_out));
            obs_cyc.push_back(cyc);
         end
      end
   end

   // ---------------- stimulus ----------------
   int last_t0;

   task automatic frame(input int in, input bit en, input int d, input int sh, input int len = 1);
      @(posedge clk);
      #1;
      sample_in   = SW'(in);
      echo_en     = en;
      delay       = AW'(d);
      decay_shift = 3'(sh);
      new_frame   = 1'b1;
      last_t0     = cyc;
      repeat (len) @(posedge clk);
      #1;
      new_frame   = 1'b0;
      // Controls wander after acceptance; the frame in flight must not notice.
      sample_in   = SW'($urandom);
      echo_en     = 1'($urandom);
      delay       = AW'($urandom);
      decay_shift = 3'($urandom);
      repeat (2) @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      int exp_imp[9];
      exp_imp = '{1000, 0, 0, 0, 500, 0, 0, 0, 250};

      repeat (3) @(posedge clk);
      #1;
      check("reset_out", int'(sample_out), 0);
      check("reset_valid", {31'b0, sample_valid}, 0);
      reset = 1'b0;

      // Pass-through and latency
      obs.delete(); obs_cyc.delete();
      frame(1000, 0, 0, 0);
      idle(3);
      check("pass_count", obs.size(), 1);
      if (obs.size() == 1) begin
         check("pass_value", obs[0], 1000);
         check("pass_latency", obs_cyc[0] - last_t0, 3);
      end

      // Impulse response, delay 4, half decay
      do_reset();
      obs.delete();
      frame(1000, 1, 4, 1);
      for (int i = 0; i < 8; i++) frame(0, 1, 4, 1);
      idle(3);
      check("impulse_count", obs.size(), 9);
      if (obs.size() == 9) begin
         for (int i = 0; i < 9; i++) check($sformatf("impulse[%0d]", i), obs[i], exp_imp[i]);
      end

      // Overflow, positive then negative
      do_reset();
      obs.delete();
      frame(100000, 1, 1, 0);
      frame(100000, 1, 1, 0);
      idle(3);
`ifdef ECHO_SATURATE_EN
      if (obs.size() == 2) check("ovf_pos", obs[1], 131071);
`else
      if (obs.size() == 2) check("ovf_pos", obs[1], -62144);
`endif
      check("ovf_pos_count", obs.size(), 2);
      do_reset();
      obs.delete();
      frame(-100000, 1, 1, 0);
      frame(-100000, 1, 1, 0);
      idle(3);
`ifdef ECHO_SATURATE_EN
      if (obs.size() == 2) check("ovf_neg", obs[1], -131072);
`else
      if (obs.size() == 2) check("ovf_neg", obs[1], 62144);
`endif
      check("ovf_neg_count", obs.size(), 2);

      // Back-to-back strobe and zero delay
      obs.delete();
      frame(1234, 0, 0, 0, 2);
      frame(555, 1, 0, 2);
      idle(3);
      check("dbl_count", obs.size(), 2);
      if (obs.size() == 2) begin
         check("dbl_value", obs[0], 1234);
         check("delay0_value", obs[1], 555);
      end

      // Pointer wrap with delay 3: out[n] = n+1 + out[n-3]
      do_reset();
      obs.delete();
      for (int k = 1; k <= 12; k++) frame(k, 1, 3, 0);
      idle(3);
      check("wrap_count", obs.size(), 12);
      if (obs.size() == 12) begin
         check("wrap_out8", obs[8], 18);
         check("wrap_out11", obs[11], 30);
      end
      obs.delete();
      frame(-4000, 1, 3, 2);
      frame(7, 0, 3, 0);
      frame(8, 1, 7, 1);
      idle(3);
      if (obs.size() == 3) check("en_off_full_buf", obs[1], 7);
      check("mix_count", obs.size(), 3);

      // Reset during READ, then during WRITE: frames are dropped, fill restarts
      obs.delete();
      @(posedge clk);
      #1 sample_in = SW'(500); echo_en = 1'b1; delay = AW'(1); new_frame = 1'b1;
      @(posedge clk);
      #1 new_frame = 1'b0; reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      new_frame = 1'b1;
      @(posedge clk);
      #1 new_frame = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      idle(4);
      check("abort_count", obs.size(), 0);
      frame(777, 1, 1, 0);
      frame(1, 1, 1, 0);
      idle(3);
      check("post_abort_count", obs.size(), 2);
      if (obs.size() == 2) begin
         check("post_abort_pass", obs[0], 777);
         check("post_abort_echo", obs[1], 778);
      end

      idle(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/echo_unit.md
ECHO_UNIT -- requirements
Module: echo_unit

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 18, signed sample width.
REQ-002 SHALL have parameter ADDR_W, default 12, delay buffer address width; depth = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port new_frame  input  1  one-cycle strobe; sample_in valid this cycle.
REQ-006 SHALL have port sample_in  input  SAMPLE_W  signed dry sample from the music player.
REQ-007 SHALL have port echo_en  input  1  level; 0 selects pass-through.
REQ-008 SHALL have port delay  input  ADDR_W  echo delay in frames, sampled at new_frame.
REQ-009 SHALL have port decay_shift  input  3  arithmetic right shift applied to the echo term, sampled at new_frame.
REQ-010 SHALL have port sample_out  output  SAMPLE_W  signed wet sample, registered, to the codec.
REQ-011 SHALL have port sample_valid  output  1  one-cycle strobe when sample_out updates.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, READ, WRITE.
REQ-013 IDLE->READ on new_frame=1: latch sample_in, delay, decay_shift, echo_en; drive RAM read address (wp - delay) mod depth.
REQ-014 READ->WRITE unconditionally; RAM read data is valid at the end of READ (1-cycle read latency).
REQ-015 WRITE->IDLE unconditionally: compute sum, register sample_out, write sum to buf[wp], increment wp mod depth.
REQ-016 Latency: new_frame in cycle T -> sample_out and sample_valid=1 in cycle T+3; sample_valid=0 in all other cycles.
REQ-017 Sum = in + (echo >>> decay_shift), computed at SAMPLE_W+1 bits; echo = RAM data when active, else 0.
REQ-018 Echo is active only if echo_en=1, delay!=0 and fill >= delay; fill counts writes since reset and saturates at depth.
REQ-019 With the echo inactive, sample_out SHALL equal the latched sample_in exactly; the buffer is still written and wp still advances.
REQ-020 The buffer stores the wet sum (feedback echo), not the dry input.
REQ-021 new_frame asserted while the state is READ or WRITE SHALL be ignored; no sample is produced for it.
REQ-022 wp SHALL wrap from depth-1 to 0; read address arithmetic SHALL wrap modulo depth.
REQ-023 Changes to delay or decay_shift SHALL take effect only at the next accepted new_frame.

Reset
REQ-024 On reset: state=IDLE, wp=0, fill=0, sample_out=0, sample_valid=0.
REQ-025 RAM contents SHALL NOT be cleared; stale data is masked by fill (REQ-018).
REQ-026 Reset in READ or WRITE SHALL abort the frame: no RAM write, no sample_valid.

Configuration
REQ-027 Macro ECHO_SATURATE_EN defined: a sum outside the SAMPLE_W signed range SHALL clamp to max/min (+131071 / -131072 at 18 bits).
REQ-028 Macro ECHO_SATURATE_EN undefined: the sum SHALL truncate to SAMPLE_W bits (two's-complement wrap).

Structure
REQ-029 Package echo_pkg SHALL hold SAMPLE_W, ADDR_W defaults, the FSM state enum, and the saturation min/max constants.
REQ-030 Sub-module echo_ram SHALL be a single-port synchronous RAM, depth 2**ADDR_W x SAMPLE_W, 1-cycle read latency; read and write never occur in the same cycle.

Verification
REQ-031 echo_en=0, sample_in=1000, new_frame at T -> sample_out=1000, sample_valid=1 at T+3 only.
REQ-032 echo_en=1, delay=4, decay_shift=1, impulse 1000 then zeros -> outputs 1000,0,0,0,500,0,0,0,250.
REQ-033 ECHO_SATURATE_EN defined, delay=1, decay_shift=0, sample_in=100000 repeated -> second output 131071; undefined -> 200000 wrapped to 18 bits (-62144).
REQ-034 new_frame pulses at T and T+1 -> exactly one sample_valid, at T+3.
REQ-035 ADDR_W=3, delay=3, more than 8 frames -> wp wraps 7->0 and echo still reads frame n-3.
REQ-036 Reset asserted at T+1 after new_frame at T -> no sample_valid; next frame with delay=1 gives pass-through (fill=0).
